// File: rtl/sdiv_axis.sv
// Signed fixed-point radix-2 restoring divider with valid/ready handshakes on both sides.
// One quotient bit per cycle; the signed, saturated result is registered on the last iteration.

module sdiv_axis #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned TAG_W     = 8
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_dividend,
    input  logic [WIDTH-1:0] s_divisor,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_quotient,
    output logic [WIDTH-1:0] m_remainder,
    output logic [TAG_W-1:0] m_tag,
    output logic             m_dbz,
    output logic             m_ovf
);

    localparam int unsigned N     = WIDTH + FRAC_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);

    localparam logic [N-1:0]     QLIM = {{(N-1){1'b0}}, 1'b1} << (WIDTH - 1);
    localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [N-1:0]     r_num;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_dvd;
    logic             r_qneg;
    logic [TAG_W-1:0] r_tag_in;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [TAG_W-1:0] r_tag_out;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [N-1:0]     w_num_init;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [N-1:0]     w_num_next;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_r_res;
    logic             w_dbz_res;
    logic             w_ovf_res;
    logic             w_last;
    logic             w_accept;

    assign w_last   = (r_cnt == CNT_W'(1));
    assign w_accept = s_valid & s_ready;

    // Magnitudes are unsigned WIDTH-bit, so |MIN| = 2^(WIDTH-1) is representable.
    always_comb begin
        w_dvd_mag  = s_dividend[WIDTH-1] ? -s_dividend : s_dividend;
        w_dvs_mag  = s_divisor[WIDTH-1] ? -s_divisor : s_divisor;
        w_num_init = '0;
        w_num_init[WIDTH-1:0] = w_dvd_mag;
        w_num_init = w_num_init << FRAC_BITS;
    end

    // r_num shifts numerator bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        w_rem_shift = {r_rem, r_num[N-1]};
        w_diff      = w_rem_shift - {1'b0, r_den};
        w_qbit      = ~w_diff[WIDTH];
        w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_num_next  = {r_num[N-2:0], w_qbit};
    end

    // Full N-bit magnitude is compared before narrowing, so no overflow escapes truncation.
    always_comb begin
        w_q_res   = r_qneg ? -w_num_next[WIDTH-1:0] : w_num_next[WIDTH-1:0];
        w_r_res   = r_dvd[WIDTH-1] ? -w_rem_next : w_rem_next;
        w_dbz_res = 1'b0;
        w_ovf_res = 1'b0;
        if (r_den == '0) begin
            w_dbz_res = 1'b1;
            w_q_res   = r_dvd[WIDTH-1] ? QMIN : QMAX;
            w_r_res   = r_dvd;
        end else if (r_qneg ? (w_num_next > QLIM) : (w_num_next >= QLIM)) begin
            w_ovf_res = 1'b1;
            w_q_res   = r_qneg ? QMIN : QMAX;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        case (r_state)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_state_next = StCalc;
                end
            end
            StCalc: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_num     <= '0;
            r_rem     <= '0;
            r_den     <= '0;
            r_dvd     <= '0;
            r_qneg    <= 1'b0;
            r_tag_in  <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_tag_out <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_num    <= w_num_init;
            r_rem    <= '0;
            r_den    <= w_dvs_mag;
            r_dvd    <= s_dividend;
            r_qneg   <= s_dividend[WIDTH-1] ^ s_divisor[WIDTH-1];
            r_tag_in <= s_tag;
            r_cnt    <= CNT_W'(N);
        end else if (r_state == StCalc) begin
            r_num <= w_num_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_q       <= w_q_res;
                r_r       <= w_r_res;
                r_tag_out <= r_tag_in;
                r_dbz     <= w_dbz_res;
                r_ovf     <= w_ovf_res;
            end
        end
    end

    assign m_quotient  = r_q;
    assign m_remainder = r_r;
    assign m_tag       = r_tag_out;
    assign m_dbz       = r_dbz;
    assign m_ovf       = r_ovf;

endmodule

// File: tb/tb_sdiv_axis.sv
// Bench for sdiv_axis: directed table, backpressure, back-to-back, mid-operation reset and
// randomized operands against an integer-arithmetic reference, on FRAC_BITS=0 and 16 instances.

module tb_sdiv_axis;

    localparam int W  = 32;
    localparam int TW = 8;
    localparam longint QMAX_L = 64'sd2147483647;
    localparam longint QMIN_L = -QMAX_L - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_valid [2];
    logic          s_ready [2];
    logic [W-1:0]  s_dvd   [2];
    logic [W-1:0]  s_dvs   [2];
    logic [TW-1:0] s_tag   [2];
    logic          m_valid [2];
    logic          m_ready [2];
    logic [W-1:0]  m_q     [2];
    logic [W-1:0]  m_r     [2];
    logic [TW-1:0] m_tag   [2];
    logic          m_dbz   [2];
    logic          m_ovf   [2];

    // Instance 0: FRAC_BITS=0, instance 1: FRAC_BITS=16.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdiv_axis #(
            .WIDTH    (W),
            .FRAC_BITS(g * 16),
            .TAG_W    (TW)
        ) u_dut (
            .clk_in     (clk),
            .rst_in_n   (rst_n),
            .s_valid    (s_valid[g]),
            .s_ready    (s_ready[g]),
            .s_dividend (s_dvd[g]),
            .s_divisor  (s_dvs[g]),
            .s_tag      (s_tag[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready[g]),
            .m_quotient (m_q[g]),
            .m_remainder(m_r[g]),
            .m_tag      (m_tag[g]),
            .m_dbz      (m_dbz[g]),
            .m_ovf      (m_ovf[g])
        );
    end

    typedef struct {
        int            sel;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dbz;
        logic          ovf;
    } vec_t;

    vec_t tbl [14];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer division of a*2^f by b, then saturation.
    function automatic void ref_div(input int f, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz, output logic ovf);
        longint na, nb, num, quo, rem;
        na  = longint'($signed(a));
        nb  = longint'($signed(b));
        dbz = 1'b0;
        ovf = 1'b0;
        if (nb == 0) begin
            dbz = 1'b1;
            q   = (na < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r   = a;
        end else begin
            num = na * (longint'(1) << f);
            quo = num / nb;
            rem = num % nb;
            if (quo > QMAX_L) begin
                q   = 32'h7FFF_FFFF;
                ovf = 1'b1;
            end else if (quo < QMIN_L) begin
                q   = 32'h8000_0000;
                ovf = 1'b1;
            end else begin
                q = quo[W-1:0];
            end
            r = rem[W-1:0];
        end
    endfunction

    // Latency counts clock cycles inclusively from the accepting cycle to the first valid cycle.
    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input bit noisy,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic [TW-1:0] t, output logic dbz, output logic ovf,
                          output int lat);
        int e;
        @(negedge clk);
        e = 0;
        while (!s_ready[sel] && e < 200) begin
            @(negedge clk);
            e++;
        end
        check("s_ready before op", 64'(s_ready[sel]), 64'(1));
        s_dvd[sel]   = a;
        s_dvs[sel]   = b;
        s_tag[sel]   = tag;
        s_valid[sel] = 1'b1;
        @(negedge clk);
        s_valid[sel] = 1'b0;
        e = 0;
        while (!m_valid[sel] && e < 200) begin
            if (noisy) begin
                s_valid[sel] = 1'($urandom);
                m_ready[sel] = 1'($urandom);
                s_dvd[sel]   = $urandom;
                s_dvs[sel]   = $urandom;
                s_tag[sel]   = 8'($urandom);
            end
            @(negedge clk);
            e++;
        end
        lat = e + 1;
        q   = m_q[sel];
        r   = m_r[sel];
        t   = m_tag[sel];
        dbz = m_dbz[sel];
        ovf = m_ovf[sel];
        s_valid[sel] = 1'b0;
        m_ready[sel] = 1'b1;
        @(negedge clk);
        m_ready[sel] = 1'b0;
        check("m_valid after handshake", 64'(m_valid[sel]), 64'(0));
    endtask

    task automatic check_op(input string name, input int sel, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [TW-1:0] tag, input bit noisy,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ed, input logic eo);
        logic [W-1:0]  q, r;
        logic [TW-1:0] t;
        logic          dbz, ovf;
        int            lat;
        run_op(sel, a, b, tag, noisy, q, r, t, dbz, ovf, lat);
        check({name, " quotient"}, 64'(q), 64'(eq));
        check({name, " remainder"}, 64'(r), 64'(er));
        check({name, " tag"}, 64'(t), 64'(tag));
        check({name, " dbz"}, 64'(dbz), 64'(ed));
        check({name, " ovf"}, 64'(ovf), 64'(eo));
        check({name, " latency"}, 64'(lat), 64'(W + sel * 16 + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  eq, er, ba [3], bb [3];
        logic [TW-1:0] bt [3];
        logic          ed, eo;
        int            times [3];
        int            got, idx, cyc, e;
        bit            adv;

        tbl[0]  = '{0, 32'd65535,      32'd9,          8'h11, 32'd7281,     32'd6,        1'b0, 1'b0};
        tbl[1]  = '{0, 32'hFFFF_FFF9,  32'd2,          8'h21, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2]  = '{0, 32'd7,          32'hFFFF_FFFE,  8'h22, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0};
        tbl[3]  = '{0, 32'd255,        32'd12,         8'h23, 32'd21,       32'd3,        1'b0, 1'b0};
        tbl[4]  = '{0, 32'd1111,       32'd0,          8'h24, 32'h7FFF_FFFF, 32'd1111,     1'b1, 1'b0};
        tbl[5]  = '{0, 32'hFFFF_FFFB,  32'd0,          8'h25, 32'h8000_0000, 32'hFFFF_FFFB, 1'b1, 1'b0};
        tbl[6]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  8'h26, 32'h7FFF_FFFF, 32'd0,        1'b0, 1'b1};
        tbl[7]  = '{1, 32'd1,          32'd4,          8'h31, 32'h0000_4000, 32'd0,        1'b0, 1'b0};
        tbl[8]  = '{1, 32'h7FFF_0000,  32'd1,          8'h32, 32'h7FFF_FFFF, 32'd0,        1'b0, 1'b1};
        tbl[9]  = '{1, 32'hFFFF_FFFF,  32'd3,          8'h33, 32'hFFFF_AAAB, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[10] = '{1, 32'h8000_0000,  32'h0001_0000,  8'h34, 32'h8000_0000, 32'd0,        1'b0, 1'b0};
        tbl[11] = '{0, 32'h8000_0000,  32'd1,          8'h27, 32'h8000_0000, 32'd0,        1'b0, 1'b0};
        tbl[12] = '{0, 32'h8000_0000,  32'h8000_0000,  8'h28, 32'd1,        32'd0,        1'b0, 1'b0};
        tbl[13] = '{0, 32'h7FFF_FFFF,  32'h8000_0000,  8'h29, 32'd0,        32'h7FFF_FFFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_dvd[i]   = '0;
            s_dvs[i]   = '0;
            s_tag[i]   = '0;
            m_ready[i] = 1'b0;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            check("reset s_ready", 64'(s_ready[i]), 64'(1));
            check("reset m_valid", 64'(m_valid[i]), 64'(0));
            check("reset m_quotient", 64'(m_q[i]), 64'(0));
            check("reset m_remainder", 64'(m_r[i]), 64'(0));
            check("reset m_tag", 64'(m_tag[i]), 64'(0));
            check("reset flags", 64'({m_dbz[i], m_ovf[i]}), 64'(0));
        end
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].tag, 1'b0,
                     tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf);
        end

        // Backpressure: result held 20 cycles while new operands are offered.
        @(negedge clk);
        s_dvd[0] = 32'hFFF0_BDC0; s_dvs[0] = 32'd37; s_tag[0] = 8'h5A; s_valid[0] = 1'b1;
        @(negedge clk);
        s_valid[0] = 1'b0;
        e = 0;
        while (!m_valid[0] && e < 200) begin
            @(negedge clk);
            e++;
        end
        ref_div(0, 32'hFFF0_BDC0, 32'd37, eq, er, ed, eo);
        for (int c = 0; c < 20; c++) begin
            check("bp m_valid", 64'(m_valid[0]), 64'(1));
            check("bp s_ready", 64'(s_ready[0]), 64'(0));
            check("bp quotient", 64'(m_q[0]), 64'(eq));
            check("bp remainder", 64'(m_r[0]), 64'(er));
            check("bp tag", 64'(m_tag[0]), 64'(8'h5A));
            s_valid[0] = 1'b1;
            s_dvd[0]   = $urandom;
            s_dvs[0]   = $urandom;
            s_tag[0]   = 8'($urandom);
            @(negedge clk);
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        @(negedge clk);
        m_ready[0] = 1'b0;
        check("bp release m_valid", 64'(m_valid[0]), 64'(0));

        // Back-to-back with s_valid and m_ready held high.
        ba[0] = 32'd1000;       bb[0] = 32'd7;          bt[0] = 8'hA0;
        ba[1] = 32'hFFFE_7961;  bb[1] = 32'd13;         bt[1] = 8'hA1;
        ba[2] = 32'd42;         bb[2] = 32'hFFFF_FFFB;  bt[2] = 8'hA2;
        @(negedge clk);
        m_ready[0] = 1'b1;
        idx = 0;
        s_dvd[0] = ba[0]; s_dvs[0] = bb[0]; s_tag[0] = bt[0]; s_valid[0] = 1'b1;
        adv = s_ready[0];
        got = 0;
        cyc = 0;
        for (int i = 0; i < 3; i++) times[i] = 0;
        while (got < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (adv) begin
                idx++;
                if (idx < 3) begin
                    s_dvd[0] = ba[idx]; s_dvs[0] = bb[idx]; s_tag[0] = bt[idx];
                end else begin
                    s_valid[0] = 1'b0;
                end
            end
            adv = s_valid[0] && s_ready[0];
            if (m_valid[0]) begin
                ref_div(0, ba[got], bb[got], eq, er, ed, eo);
                check("b2b quotient", 64'(m_q[0]), 64'(eq));
                check("b2b remainder", 64'(m_r[0]), 64'(er));
                check("b2b tag", 64'(m_tag[0]), 64'(bt[got]));
                times[got] = cyc;
                got++;
            end
        end
        check("b2b result count", 64'(got), 64'(3));
        check("b2b spacing 0-1", 64'(times[1] - times[0]), 64'(W + 2));
        check("b2b spacing 1-2", 64'(times[2] - times[1]), 64'(W + 2));
        @(negedge clk);
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b0;

        // Asynchronous reset in the middle of CALC, then a clean operation.
        @(negedge clk);
        s_dvd[0] = 32'd123456789; s_dvs[0] = 32'hFFFF_FC18; s_tag[0] = 8'h77; s_valid[0] = 1'b1;
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid-reset m_valid", 64'(m_valid[0]), 64'(0));
        check("mid-reset s_ready", 64'(s_ready[0]), 64'(1));
        check("mid-reset m_quotient", 64'(m_q[0]), 64'(0));
        #3 rst_n = 1'b1;
        ref_div(0, 32'd98765, 32'hFFFF_FFF5, eq, er, ed, eo);
        check_op("post-reset", 0, 32'd98765, 32'hFFFF_FFF5, 8'h78, 1'b0, eq, er, ed, eo);

        // Randomized operands with noise on s_valid/m_ready during CALC.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            int           sel;
            sel = i % 2;
            a   = 32'($signed($urandom) >>> $urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = 32'h8000_0000;
                default: b = 32'($signed($urandom) >>> $urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            ref_div(sel * 16, a, b, eq, er, ed, eo);
            check_op($sformatf("rand[%0d]", i), sel, a, b, 8'($urandom), 1'b1, eq, er, ed, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
